x_vec_tx: RTL and testbench
===========================

X_VEC_TX -- requirements
Module: x_vec_tx

Interface
REQ-001 Parameter T, default 8, sample width in bits (signed two's complement).
REQ-002 Parameter N, default 128, samples per vector; power of two, at least 4.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_valid_ld  input  1  host load sample valid.
REQ-006 s_data_ld  input  T  host load sample, signed.
REQ-007 s_ready_ld  output  1  block can accept a load sample.
REQ-008 m_valid_x  output  1  output sample valid toward the convolution X port.
REQ-009 m_ready_x  input  1  downstream accepts the output sample.
REQ-010 m_data_out_x  output  T  output sample, signed.
REQ-011 vec_done  output  1  one-cycle pulse when the last sample of a vector is accepted.

Function
REQ-012 A transfer on either port SHALL occur only in a cycle where valid and ready are both high.
REQ-013 The FSM SHALL have exactly three states: FILL, PREP and SEND.
REQ-014 FILL: s_ready_ld=1 and m_valid_x=0; each load transfer writes s_data_ld to mem[wr_addr], and wr_addr increments.
REQ-015 The load transfer at wr_addr=N-1 SHALL wrap wr_addr to 0 and move the FSM to PREP on the next edge.
REQ-016 PREP SHALL last exactly one cycle with s_ready_ld=0 and m_valid_x=0, and SHALL issue the synchronous memory read of address 0.
REQ-017 The first m_valid_x=1 SHALL appear exactly 2 cycles after the cycle of the N-th load transfer.
REQ-018 SEND: s_ready_ld=0; samples SHALL be presented in address order 0..N-1.
REQ-019 Once m_valid_x=1, m_valid_x and m_data_out_x SHALL hold stable until the transfer completes.
REQ-020 With m_ready_x held high, SEND SHALL sustain one transfer per cycle, with no bubbles, using read-ahead of the next address.
REQ-021 Downstream stalls of any length SHALL lose or duplicate no sample.
REQ-022 On the transfer of sample N-1: vec_done=1 for that same cycle, the FSM returns to FILL on the next edge, and m_valid_x=0 on the next cycle.
REQ-023 Memory contents are not cleared between vectors; every vector is fully reloaded in FILL.
REQ-024 Samples pass through bit-exact; no arithmetic, saturation or sign extension.

Reset
REQ-025 reset SHALL force state=FILL, wr_addr=0, rd_addr=0, m_valid_x=0, m_data_out_x=0, vec_done=0 and s_ready_ld=1 on the next cycle.
REQ-026 reset asserted mid-FILL or mid-SEND SHALL abandon the partial vector; the next load after reset is written to address 0.
REQ-027 Memory array contents are not reset.

Configuration
REQ-028 Macro X_VEC_TX_THROTTLE_EN, when defined, SHALL force m_valid_x=0 for exactly one cycle after every output transfer (maximum rate one sample per 2 cycles).
REQ-029 That idle cycle SHALL also follow the last sample, so the first FILL cycle coincides with it.
REQ-030 Without X_VEC_TX_THROTTLE_EN, behaviour SHALL be exactly as in REQ-020; the macro SHALL NOT change the port list.

Structure
REQ-031 The FSM state enum and the address-width constant $clog2(N) SHALL live in the shared project package.
REQ-032 Storage SHALL be one instance of the existing single-port synchronous memory sub-module "memory" (WIDTH=T, SIZE=N, LOGSIZE=$clog2(N)); the write and read address are muxed by state.

Verification
REQ-033 Load 0..127 with s_valid_ld=1 continuously and m_ready_x=1 -> first m_valid_x 2 cycles after the last load; outputs 0..127 on 128 consecutive cycles; vec_done on the sample-127 cycle.
REQ-034 Load -128..-1, then hold m_ready_x=0 for 10 cycles, then set it to 1 -> m_data_out_x=-128 held stable through the stall; order correct; no drops.
REQ-035 Toggle m_ready_x every cycle during SEND -> exactly 128 transfers, matching the loaded order; s_ready_ld=0 throughout SEND.
REQ-036 Pulse reset after 64 outputs, then load a new ramp 100.. -> output restarts from 100; no stale sample and no vec_done for the aborted vector.
REQ-037 Send two back-to-back vectors A then B -> B is loadable exactly one cycle after vec_done for A; output B matches B.
REQ-038 With X_VEC_TX_THROTTLE_EN defined and m_ready_x=1 -> m_valid_x pattern is 1,0,1,0...; 128 samples over 255 cycles.

Source files
------------

// File: rtl/x_vec_tx_pkg.sv
// Shared definitions for the x_vec_tx vector transmitter: FSM state encoding,
// default vector length and the address-width helper.
package x_vec_tx_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PREP = 2'd1,
    SEND = 2'd2
  } vec_state_t;

  localparam int unsigned VEC_N_DEFAULT = 128;

  // Address width for a vector of n samples: $clog2(n).
  function automatic int unsigned vec_aw(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/x_vec_tx_memory.sv
// Single-port synchronous memory: one address shared by write and read,
// registered read data (read-before-write on a simultaneous access).
module memory #(
  parameter int WIDTH   = 8,
  parameter int SIZE    = 128,
  parameter int LOGSIZE = 7
) (
  input  logic               clk,
  input  logic               we,
  input  logic [LOGSIZE-1:0] addr,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0] mem [SIZE];

  // Write on we, always register the addressed word onto dout.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/x_vec_tx.sv
// x_vec_tx: loads an N-sample vector from the host, then streams it in
// address order toward the convolution X port with valid/ready handshakes.
// Optional macro X_VEC_TX_THROTTLE_EN inserts one idle cycle after every
// output transfer.
module x_vec_tx
  import x_vec_tx_pkg::*;
#(
  parameter int T = 8,
  parameter int N = VEC_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid_ld,
  input  logic [T-1:0] s_data_ld,
  output logic         s_ready_ld,
  output logic         m_valid_x,
  input  logic         m_ready_x,
  output logic [T-1:0] m_data_out_x,
  output logic         vec_done
);

  localparam int unsigned AW = vec_aw(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  vec_state_t    state, state_next;
  logic [AW-1:0] wr_addr, rd_addr, mem_addr;
  logic          mem_we;
  logic [T-1:0]  mem_dout;
  logic          fire;
  logic          gap;

`ifdef X_VEC_TX_THROTTLE_EN
  // Idle flag: high for the single cycle following every output transfer.
  always_ff @(posedge clk) begin
    if (reset) gap <= 1'b0;
    else       gap <= fire;
  end
`else
  assign gap = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  // Write pointer advances per load, read pointer per output transfer;
  // both wrap naturally at N because N is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      if (state == FILL && s_valid_ld) wr_addr <= wr_addr + 1'b1;
      if (fire)                        rd_addr <= rd_addr + 1'b1;
    end
  end

  // Next state, handshake outputs and the shared memory address mux.
  // In SEND the read is issued one address ahead on a transfer so the next
  // sample is on mem_dout the following cycle; on a stall the current
  // address is re-read, which keeps the presented sample stable.
  always_comb begin
    state_next = state;
    s_ready_ld = 1'b0;
    m_valid_x  = 1'b0;
    vec_done   = 1'b0;
    fire       = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = rd_addr;
    case (state)
      FILL: begin
        s_ready_ld = 1'b1;
        mem_addr   = wr_addr;
        mem_we     = s_valid_ld;
        if (s_valid_ld && wr_addr == LAST) state_next = PREP;
      end
      PREP: begin
        state_next = SEND;
      end
      SEND: begin
        m_valid_x = !gap;
        fire      = m_valid_x && m_ready_x;
        if (fire) begin
          mem_addr = rd_addr + 1'b1;
          if (rd_addr == LAST) begin
            vec_done   = 1'b1;
            state_next = FILL;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign m_data_out_x = m_valid_x ? mem_dout : '0;

  memory #(
    .WIDTH  (T),
    .SIZE   (N),
    .LOGSIZE(AW)
  ) u_mem (
    .clk (clk),
    .we  (mem_we),
    .addr(mem_addr),
    .din (s_data_ld),
    .dout(mem_dout)
  );

endmodule

// File: tb/tb_x_vec_tx.sv
// Self-checking bench for x_vec_tx: a transaction-level model (loaded count,
// send index, vector contents) predicts the handshake outputs every cycle.
module tb_x_vec_tx;

  localparam int T = 8;
  localparam int N = 128;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         s_valid_ld = 1'b0;
  logic [T-1:0] s_data_ld = '0;
  logic         s_ready_ld;
  logic         m_valid_x;
  logic         m_ready_x = 1'b0;
  logic [T-1:0] m_data_out_x;
  logic         vec_done;

  x_vec_tx #(.T(T), .N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid_ld  (s_valid_ld),
    .s_data_ld   (s_data_ld),
    .s_ready_ld  (s_ready_ld),
    .m_valid_x   (m_valid_x),
    .m_ready_x   (m_ready_x),
    .m_data_out_x(m_data_out_x),
    .vec_done    (vec_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 = loading, 1 = one prep cycle, 2 = sending.
  int           mphase = 0;
  int           mk     = 0;
  int           midx   = 0;
  logic         mgap   = 1'b0;
  logic [T-1:0] mvec [N];
  logic         armed  = 1'b0;
  int           done_seen = 0;

  always @(posedge clk) begin
    mgap <= 1'b0;
    if (reset) begin
      mphase <= 0;
      mk     <= 0;
      midx   <= 0;
    end else begin
      case (mphase)
        0: if (s_valid_ld) begin
          mvec[mk] <= s_data_ld;
          if (mk == N - 1) begin
            mk     <= 0;
            mphase <= 1;
          end else mk <= mk + 1;
        end
        1: begin
          mphase <= 2;
          midx   <= 0;
        end
        default: if (!mgap && m_ready_x) begin
`ifdef X_VEC_TX_THROTTLE_EN
          mgap <= 1'b1;
`endif
          if (midx == N - 1) begin
            mphase <= 0;
            midx   <= 0;
          end else midx <= midx + 1;
        end
      endcase
    end
  end

  // Compare every output against the model half a cycle after the edge.
  always @(negedge clk) begin
    if (armed) begin
      logic ev;
      ev = (mphase == 2) && !mgap;
      chk("s_ready_ld", 32'(s_ready_ld), 32'(mphase == 0));
      chk("m_valid_x", 32'(m_valid_x), 32'(ev));
      chk("vec_done", 32'(vec_done), 32'(ev && m_ready_x && midx == N - 1));
      if (ev) chk("m_data_out_x", 32'(m_data_out_x), 32'(mvec[midx]));
      if (vec_done) done_seen++;
    end
  end

  // One reset cycle, then confirm the cleared output data.
  task automatic do_reset();
    reset      = 1'b1;
    s_valid_ld = 1'b0;
    m_ready_x  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    chk("rst_data", 32'(m_data_out_x), 32'h0);
    chk("rst_ready", 32'(s_ready_ld), 32'h1);
    @(posedge clk); #1;
  endtask

  // Load and stream one vector. rmode: 0 ready high, 1 stall 10 cycles,
  // 2 toggle, 3 random. vmode: 0 s_valid held high with a ramp from base,
  // 1 random valid and data. abort_send/abort_fill >= 0 pulse reset at that
  // send index / load count. Called and returns at posedge+1.
  task automatic run_vec(input int base, input int rmode, input int vmode,
                         input int abort_send, input int abort_fill);
    int  scyc = 0;
    bit  started = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ((abort_send >= 0 && mphase == 2 && midx == abort_send) ||
          (abort_fill >= 0 && mphase == 0 && mk == abort_fill && mk > 0)) begin
        do_reset();
        return;
      end
      if (vmode == 0) begin
        s_valid_ld = 1'b1;
        s_data_ld  = T'(base + mk);
      end else begin
        s_valid_ld = 1'($urandom_range(0, 1));
        s_data_ld  = T'($urandom);
      end
      case (rmode)
        0:       m_ready_x = 1'b1;
        1:       m_ready_x = (scyc >= 10);
        2:       m_ready_x = (scyc % 2) == 1;
        default: m_ready_x = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      if (mphase == 2) begin
        started = 1;
        scyc++;
      end
      if (started && mphase == 0) return;
    end
    chk("timeout", 32'h1, 32'h0);
  endtask

  initial begin
    int exp_done = 0;
    @(posedge clk); #1;
    do_reset();
    run_vec(0, 0, 0, -1, -1);       exp_done++;
    run_vec(-128, 1, 0, -1, -1);    exp_done++;
    run_vec(5, 2, 0, -1, -1);       exp_done++;
    run_vec(7, 0, 0, 64, -1);
    run_vec(100, 0, 0, -1, -1);     exp_done++;
    run_vec(20, 0, 0, -1, -1);      exp_done++;
    run_vec(50, 0, 0, -1, -1);      exp_done++;
    run_vec(0, 0, 1, -1, 37);
    for (int v = 0; v < 3; v++) begin
      run_vec(0, 3, 1, -1, -1);     exp_done++;
    end
    s_valid_ld = 1'b0;
    m_ready_x  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 32'(done_seen), 32'(exp_done));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
